rf_seq: RTL and testbench

Bulk load/dump sequencer for the 8×8-bit register file. It takes a start command with a start address and length, then walks consecutive register addresses, wrapping 7→0. In load mode it writes bytes from an input valid/ready stream into the register file. In dump mode it reads registers out onto an output valid/ready stream. It sits between the debug/boot path and the register file's `data_in`/`ce`/`reg_adr`/`data_out` port, and owns that port while busy.

---
 rtl/rf_seq_if.sv | 42 ++++
 rtl/rf_seq.sv | 140 ++++++++++++++
 tb/tb_rf_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_seq_if.sv
// rf_seq_if -- command, stream and register-file port bundle for rf_seq.
//
// Optional feature: when RF_SEQ_CHECKSUM_EN is defined, rf_seq adds a
// separate 'checksum' output port. That port is not part of this bundle.
//
// Signals (direction seen from the sequencer, i.e. the 'slave' modport):
//   start, mode, start_adr, len   in   command strobe and its arguments
//   busy, done                    out  status (done is a one-cycle pulse)
//   s_data, s_valid / s_ready     in / out   load input stream
//   m_data, m_valid / m_ready     out / in   dump output stream
//   rf_data_in, rf_ce, rf_adr     out  register file write/address port
//   rf_data_out                   in   register file read data (combinational)
interface rf_seq_if;
  logic       start;
  logic       mode;
  logic [2:0] start_adr;
  logic [2:0] len;
  logic       busy;
  logic       done;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] rf_data_in;
  logic       rf_ce;
  logic [2:0] rf_adr;
  logic [7:0] rf_data_out;

  // Sequencer side.
  modport slave (
    input  start, mode, start_adr, len, s_data, s_valid, m_ready, rf_data_out,
    output busy, done, s_ready, m_data, m_valid, rf_data_in, rf_ce, rf_adr
  );

  // Controller / environment side.
  modport master (
    output start, mode, start_adr, len, s_data, s_valid, m_ready, rf_data_out,
    input  busy, done, s_ready, m_data, m_valid, rf_data_in, rf_ce, rf_adr
  );
endinterface

// File: rtl/rf_seq.sv
// rf_seq -- bulk load/dump sequencer for the 8x8-bit register file.
//
// A start command (mode, start_adr, len) walks len+1 consecutive register
// addresses, wrapping 7->0. Load mode writes bytes taken from the s_* stream
// into the register file; dump mode reads registers out onto the m_* stream.
// The sequencer owns the register file port while busy.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   bus       rf_seq_if.slave: command, status, streams, register file port
//   checksum  out  8-bit modulo-256 sum of transferred bytes
//                  (present only when RF_SEQ_CHECKSUM_EN is defined)
//
// Build option: RF_SEQ_CHECKSUM_EN enables the checksum port and its adder.
module rf_seq (
  input  logic    clk,
  input  logic    rst_n,
  rf_seq_if.slave bus
`ifdef RF_SEQ_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cur_adr;
  logic [2:0] r_remaining;
  logic       w_hs;
  logic       w_accept;

  // A start is only honoured in IDLE; anywhere else it is simply dropped.
  assign w_accept = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all port outputs. Outputs are decoded from the state only
  // (plus pass-through of stream inputs), so rf_ce falls the moment reset
  // forces the state back to IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_hs           = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.s_ready    = 1'b0;
    bus.m_valid    = 1'b0;
    bus.rf_ce      = 1'b0;
    bus.rf_adr     = 3'd0;
    bus.rf_data_in = 8'd0;
    bus.m_data     = bus.rf_data_out;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = bus.mode ? S_DUMP : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.busy       = 1'b1;
        bus.s_ready    = 1'b1;
        bus.rf_adr     = r_cur_adr;
        bus.rf_data_in = bus.s_data;
        bus.rf_ce      = bus.s_valid;
        w_hs           = bus.s_valid;
        if (w_hs && (r_remaining == 3'd0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DUMP: begin
        // Register file is never written here, so m_data is stable under
        // backpressure without any holding register.
        bus.busy    = 1'b1;
        bus.m_valid = 1'b1;
        bus.rf_adr  = r_cur_adr;
        w_hs        = bus.m_ready;
        if (w_hs && (r_remaining == 3'd0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address walker and transfer counter. remaining counts down to 0; the
  // handshake seen with remaining==0 is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_adr   <= 3'd0;
      r_remaining <= 3'd0;
    end else if (w_accept) begin
      r_cur_adr   <= bus.start_adr;
      r_remaining <= bus.len;
    end else if (w_hs) begin
      r_cur_adr <= r_cur_adr + 3'd1;
      if (r_remaining != 3'd0) begin
        r_remaining <= r_remaining - 3'd1;
      end
    end
  end

`ifdef RF_SEQ_CHECKSUM_EN
  logic [7:0] r_checksum;
  logic [7:0] w_xfer_byte;

  assign w_xfer_byte = (r_state == S_DUMP) ? bus.rf_data_out : bus.s_data;

  // Running sum; holds after the last transfer until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 8'd0;
    end else if (w_accept) begin
      r_checksum <= 8'd0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + w_xfer_byte;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq -- randomized self-checking bench for rf_seq.
//
// The bench hosts a behavioural 8x8 register file on the DUT's rf_* port and
// keeps a reference image of what that register file must contain, updated
// from the transfer rules (address = start_adr + i modulo 8).
module tb_rf_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_seq_if bus();

`ifdef RF_SEQ_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rf_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RF_SEQ_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  // Behavioural register file (no reset) with a bench-only preload port.
  logic [7:0] rf_mem [8];
  logic       pre_we = 1'b0;
  logic [2:0] pre_adr = 3'd0;
  logic [7:0] pre_data = 8'd0;

  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_adr] <= pre_data;
    else if (bus.rf_ce) rf_mem[bus.rf_adr] <= bus.rf_data_in;
  end
  assign bus.rf_data_out = rf_mem[bus.rf_adr];

  logic [7:0] ref_mem [8];
  logic [7:0] tx_bytes [8];
  logic [7:0] exp_sum;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int j = 0; j < 8; j++) chk(tag, rf_mem[j], ref_mem[j]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_rf_ce"}, bus.rf_ce, 0);
    chk({tag, "_rf_adr"}, bus.rf_adr, 0);
    chk({tag, "_rf_data_in"}, bus.rf_data_in, 0);
  endtask

  task automatic issue_start(input logic md, input logic [2:0] adr, input logic [2:0] ln);
    bus.start = 1'b1;
    bus.mode = md;
    bus.start_adr = adr;
    bus.len = ln;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode = 1'($urandom);
    bus.start_adr = 3'($urandom);
    bus.len = 3'($urandom);
    #1;
    chk("busy_rise", bus.busy, 1);
  endtask

  // Called at a negedge in the cycle following the last handshake.
  task automatic finish_xfer(input bit start_in_done);
    if (start_in_done) begin
      bus.start = 1'b1;
      bus.mode = 1'($urandom);
    end
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_s_ready", bus.s_ready, 0);
    chk("done_m_valid", bus.m_valid, 0);
    chk("done_rf_ce", bus.rf_ce, 0);
`ifdef RF_SEQ_CHECKSUM_EN
    chk("csum_done", checksum, exp_sum);
`endif
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk_idle_outputs("after_done");
`ifdef RF_SEQ_CHECKSUM_EN
    chk("csum_held", checksum, exp_sum);
`endif
    @(negedge clk);
  endtask

  task automatic do_load(input logic [2:0] adr, input logic [2:0] ln, input int max_stall,
                         input bit inject_start, input bit start_in_done);
    logic [2:0] a;
    int k;
    issue_start(1'b0, adr, ln);
    exp_sum = 8'd0;
    for (int i = 0; i <= int'(ln); i++) begin
      a = adr + 3'(i);
      k = (max_stall > 0) ? $urandom_range(max_stall, 0) : 0;
      repeat (k) begin
        bus.s_valid = 1'b0;
        bus.s_data = 8'($urandom);
        #1;
        chk("load_stall_ce", bus.rf_ce, 0);
        chk("load_stall_ready", bus.s_ready, 1);
        chk("load_stall_adr", bus.rf_adr, a);
        @(negedge clk);
      end
      bus.s_valid = 1'b1;
      bus.s_data = tx_bytes[i];
      if (inject_start && i == 1) begin
        bus.start = 1'b1;
        bus.mode = 1'b1;
        bus.start_adr = adr + 3'd3;
      end
      #1;
      chk("load_adr", bus.rf_adr, a);
      chk("load_ce", bus.rf_ce, 1);
      chk("load_data_in", bus.rf_data_in, tx_bytes[i]);
      chk("load_busy", bus.busy, 1);
      chk("load_done_low", bus.done, 0);
      @(negedge clk);
      bus.start = 1'b0;
      ref_mem[a] = tx_bytes[i];
      exp_sum = exp_sum + tx_bytes[i];
    end
    bus.s_valid = 1'b0;
    finish_xfer(start_in_done);
    chk_mem("load_mem");
  endtask

  task automatic do_dump(input logic [2:0] adr, input logic [2:0] ln, input int max_stall,
                         input int fix_idx, input int fix_n);
    logic [2:0] a;
    int k;
    issue_start(1'b1, adr, ln);
    exp_sum = 8'd0;
    for (int i = 0; i <= int'(ln); i++) begin
      a = adr + 3'(i);
      k = (i == fix_idx) ? fix_n : ((max_stall > 0) ? $urandom_range(max_stall, 0) : 0);
      repeat (k) begin
        bus.m_ready = 1'b0;
        #1;
        chk("dump_stall_valid", bus.m_valid, 1);
        chk("dump_stall_data", bus.m_data, ref_mem[a]);
        chk("dump_stall_adr", bus.rf_adr, a);
        chk("dump_stall_ce", bus.rf_ce, 0);
        @(negedge clk);
      end
      bus.m_ready = 1'b1;
      #1;
      chk("dump_valid", bus.m_valid, 1);
      chk("dump_data", bus.m_data, ref_mem[a]);
      chk("dump_adr", bus.rf_adr, a);
      chk("dump_ce", bus.rf_ce, 0);
      chk("dump_s_ready", bus.s_ready, 0);
      @(negedge clk);
      exp_sum = exp_sum + ref_mem[a];
    end
    bus.m_ready = 1'b0;
    finish_xfer(1'b0);
    chk_mem("dump_mem");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.start_adr = 3'd0;
    bus.len = 3'd0;
    bus.s_data = 8'd0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Preload the register file with random contents while in reset.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_adr = 3'(j);
      pre_data = 8'($urandom);
      ref_mem[j] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    #1;
    chk_idle_outputs("reset");
`ifdef RF_SEQ_CHECKSUM_EN
    chk("reset_csum", checksum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load 0x10..0x17 into 0..7 back-to-back, then dump it back.
    for (int j = 0; j < 8; j++) tx_bytes[j] = 8'h10 + 8'(j);
    do_load(3'd0, 3'd7, 0, 1'b0, 1'b0);
    do_dump(3'd0, 3'd7, 0, -1, 0);

    // Wrap-around load: addresses 6, 7, 0.
    tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'hA2; tx_bytes[2] = 8'hA3;
    do_load(3'd6, 3'd2, 0, 1'b0, 1'b0);

    // Backpressure: 3 stall cycles on the second dumped byte.
    do_dump(3'd5, 3'd4, 0, 1, 3);

    // start pulses mid-load and in the DONE cycle are both ignored.
    for (int j = 0; j < 8; j++) tx_bytes[j] = 8'($urandom);
    do_load(3'd2, 3'd5, 0, 1'b1, 1'b1);

    // Checksum wrap: 0xFF + 0x02 + 0x80 = 0x81.
    tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h80;
    do_load(3'd4, 3'd2, 0, 1'b0, 1'b0);
`ifdef RF_SEQ_CHECKSUM_EN
    chk("csum_0x81", checksum, 8'h81);
`endif

    // Randomized transfers with random stalls.
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < 8; j++) tx_bytes[j] = 8'($urandom);
      if ($urandom_range(1, 0) == 1)
        do_dump(3'($urandom), 3'($urandom), 2, -1, 0);
      else
        do_load(3'($urandom), 3'($urandom), 2, 1'b0, 1'b0);
    end

    // Reset after 3 of 8 writes: outputs drop at once, no further writes.
    for (int j = 0; j < 8; j++) tx_bytes[j] = 8'($urandom);
    issue_start(1'b0, 3'd0, 3'd7);
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = tx_bytes[i];
      @(negedge clk);
      ref_mem[i] = tx_bytes[i];
    end
    bus.s_data = tx_bytes[3];
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
`ifdef RF_SEQ_CHECKSUM_EN
    chk("mid_reset_csum", checksum, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk_mem("mid_reset_mem");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_idle_outputs("post_reset");
    @(negedge clk);
    do_dump(3'd0, 3'd7, 1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
